mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM between three requesters: CPU instruction fetch, CPU load/store, and the program loader. Arbitration and sequencing use a small FSM. The block sits between `cpu` and the memory macro. It drives `cpu_stall` so the single-cycle core holds state while its fetch or data access is outstanding. The loader has priority but is rate-limited, so the CPU is never starved.

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters (fetch, load/store, loader), the arbiter
// and the single-port memory macro. The arbiter side uses the slave modport;
// the requester/memory side uses the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_mask;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [MASK_W-1:0] ld_mask;
  logic              ld_ack;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [MASK_W-1:0] m_mask;
  logic [DATA_W-1:0] m_rdata;

  logic              cpu_stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mask,
    input  ld_req, ld_addr, ld_wdata, ld_mask, m_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, ld_ack,
    output m_en, m_we, m_addr, m_wdata, m_mask, cpu_stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mask,
    output ld_req, ld_addr, ld_wdata, ld_mask, m_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, ld_ack,
    input  m_en, m_we, m_addr, m_wdata, m_mask, cpu_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between CPU fetch, CPU
// load/store and the program loader.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | arbitrate; writes complete here at 1/cycle
//   RD_WAIT | read command issued last cycle; ack owner next cycle
//
// The loader is a write streamer that presents its next beat in its ack
// cycle, so it is not excluded while acked; the CPU ports are, since a
// single-cycle core still shows the old request during its ack cycle.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MASK_W       = 16,
  parameter int LD_BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(LD_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] LD_MAX = CNT_W'(LD_BURST_MAX);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state_q, state_d;
  logic              own_data_q, own_data_d;   // 1: data port owns the read
  logic              rr_q, rr_d;               // 1: fetch favoured
  logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic              m_en_q, m_en_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [MASK_W-1:0] m_mask_q, m_mask_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              ld_ack_q, ld_ack_d;

  logic if_elig, d_elig, ld_elig, cpu_elig, ld_wins, pick_data;

  assign if_elig  = bus.if_req & ~if_ack_q;
  assign d_elig   = bus.d_req & ~d_ack_q;
  assign ld_elig  = bus.ld_req;
  assign cpu_elig = if_elig | d_elig;
  assign ld_wins  = ld_elig & ((ld_cnt_q < LD_MAX) | ~cpu_elig);
  assign pick_data = d_elig & (~if_elig | ~rr_q);

  // Next-state, arbitration and memory command decode.
  always_comb begin
    state_d    = state_q;
    own_data_d = own_data_q;
    rr_d       = rr_q;
    ld_cnt_d   = cpu_elig ? ld_cnt_q : '0;
    m_en_d     = 1'b0;
    m_we_d     = 1'b0;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_mask_d   = m_mask_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    ld_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_wins) begin
          m_en_d    = 1'b1;
          m_we_d    = 1'b1;
          m_addr_d  = bus.ld_addr;
          m_wdata_d = bus.ld_wdata;
          m_mask_d  = bus.ld_mask;
          ld_ack_d  = 1'b1;
          // ld_wins with a CPU waiting implies ld_cnt_q < LD_MAX.
          if (cpu_elig) ld_cnt_d = ld_cnt_q + 1'b1;
        end else if (cpu_elig) begin
          ld_cnt_d = '0;
          rr_d     = pick_data;
          m_en_d   = 1'b1;
          if (pick_data) begin
            m_we_d    = bus.d_we;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            m_mask_d  = bus.d_mask;
            if (bus.d_we) begin
              d_ack_d = 1'b1;
            end else begin
              state_d    = RD_WAIT;
              own_data_d = 1'b1;
            end
          end else begin
            m_addr_d   = bus.if_addr;
            state_d    = RD_WAIT;
            own_data_d = 1'b0;
          end
        end
      end
      RD_WAIT: begin
        state_d  = IDLE;
        d_ack_d  = own_data_q;
        if_ack_d = ~own_data_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered memory command / acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      own_data_q <= 1'b0;
      rr_q       <= 1'b0;
      ld_cnt_q   <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_mask_q   <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      ld_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_data_q <= own_data_d;
      rr_q       <= rr_d;
      ld_cnt_q   <= ld_cnt_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_mask_q   <= m_mask_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      ld_ack_q   <= ld_ack_d;
    end
  end

  assign bus.m_en      = m_en_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_mask    = m_mask_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.if_rdata  = bus.m_rdata;
  assign bus.d_rdata   = bus.m_rdata;
  assign bus.cpu_stall = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small read-latency memory model.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MASK_W(16), .LD_BURST_MAX(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h1);
  endfunction

  // Memory model: read data valid in the cycle after a read command.
  initial begin
    logic        pend;
    logic [31:0] addr;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      pend = bus.m_en & ~bus.m_we;
      addr = bus.m_addr;
      @(posedge clk);
      #1;
      if (pend) bus.m_rdata = mem_f(addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mask = '0;
    bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_mask = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_m_en", bus.m_en, 0);
      chk("rst_m_we", bus.m_we, 0);
      chk("rst_acks", {bus.if_ack, bus.d_ack, bus.ld_ack}, 0);
      chk("rst_m_addr", bus.m_addr, 0);
      chk("rst_m_wdata", bus.m_wdata, 0);
      chk("rst_m_mask", bus.m_mask, 0);
      chk("rst_stall", bus.cpu_stall, 0);
    end

    // Single fetch from 0x10.
    bus.if_req = 1; bus.if_addr = 32'h10;
    #1 chk("f_stall0", bus.cpu_stall, 1);
    tick();
    chk("f_m_en", bus.m_en, 1);
    chk("f_m_we", bus.m_we, 0);
    chk("f_m_addr", bus.m_addr, 32'h10);
    chk("f_ack_early", bus.if_ack, 0);
    chk("f_stall1", bus.cpu_stall, 1);
    tick();
    chk("f_ack", bus.if_ack, 1);
    chk("f_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    chk("f_m_en_off", bus.m_en, 0);
    chk("f_stall2", bus.cpu_stall, 0);
    bus.if_req = 0;
    tick();
    chk("f_ack_done", bus.if_ack, 0);
    chk("f_no_regrant", bus.m_en, 0);

    // Fetch and data read held together: data, fetch, data, fetch.
    bus.if_req = 1; bus.if_addr = 32'h20;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rr_d_m_en", bus.m_en, 1);
      chk("rr_d_addr", bus.m_addr, 32'h40);
      chk("rr_d_we", bus.m_we, 0);
      chk("rr_d_noack", {bus.if_ack, bus.d_ack}, 0);
      tick();
      chk("rr_d_ack", {bus.if_ack, bus.d_ack}, 2'b01);
      chk("rr_d_rdata", bus.d_rdata, mem_f(32'h40));
      chk("rr_d_gap", bus.m_en, 0);
      if (i == 1) bus.d_req = 0;
      tick();
      chk("rr_f_m_en", bus.m_en, 1);
      chk("rr_f_addr", bus.m_addr, 32'h20);
      chk("rr_f_noack", {bus.if_ack, bus.d_ack}, 0);
      tick();
      chk("rr_f_ack", {bus.if_ack, bus.d_ack}, 2'b10);
      chk("rr_f_rdata", bus.if_rdata, mem_f(32'h20));
      chk("rr_f_gap", bus.m_en, 0);
      if (i == 1) bus.if_req = 0;
    end
    tick();
    chk("rr_quiet", {bus.m_en, bus.if_ack, bus.d_ack}, 0);

    // Loader stream against a waiting fetch: 8 loader beats, 1 fetch, loader.
    bus.if_req = 1; bus.if_addr = 32'h30;
    bus.ld_req = 1; bus.ld_addr = 32'h1000; bus.ld_wdata = 32'hA000_0000; bus.ld_mask = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("ld_ack", bus.ld_ack, 1);
      chk("ld_m_en", bus.m_en, 1);
      chk("ld_m_we", bus.m_we, 1);
      chk("ld_addr", bus.m_addr, 32'h1000 + 32'(k));
      chk("ld_wdata", bus.m_wdata, 32'hA000_0000 + 32'(k));
      chk("ld_mask", bus.m_mask, 32'hFFFF);
      chk("ld_if_wait", bus.if_ack, 0);
      chk("ld_stall", bus.cpu_stall, 1);
      bus.ld_addr  = 32'h1000 + 32'(k + 1);
      bus.ld_wdata = 32'hA000_0000 + 32'(k + 1);
    end
    tick();
    chk("ld_sat_fetch_en", bus.m_en, 1);
    chk("ld_sat_fetch_we", bus.m_we, 0);
    chk("ld_sat_fetch_addr", bus.m_addr, 32'h30);
    chk("ld_sat_no_ldack", bus.ld_ack, 0);
    tick();
    chk("ld_fetch_ack", bus.if_ack, 1);
    chk("ld_fetch_rdata", bus.if_rdata, mem_f(32'h30));
    chk("ld_fetch_gap", bus.m_en, 0);
    bus.if_req = 0;
    tick();
    chk("ld_resume_ack", bus.ld_ack, 1);
    chk("ld_resume_addr", bus.m_addr, 32'h1008);
    chk("ld_resume_we", bus.m_we, 1);
    bus.ld_req = 0;
    tick();
    chk("ld_quiet", {bus.m_en, bus.ld_ack}, 0);

    // Data write, request dropped in its ack cycle.
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100;
    bus.d_wdata = 32'h1234_5678; bus.d_mask = 16'h000F;
    tick();
    chk("w_m_en", bus.m_en, 1);
    chk("w_m_we", bus.m_we, 1);
    chk("w_addr", bus.m_addr, 32'h100);
    chk("w_wdata", bus.m_wdata, 32'h1234_5678);
    chk("w_mask", bus.m_mask, 32'h000F);
    chk("w_ack", bus.d_ack, 1);
    chk("w_stall", bus.cpu_stall, 0);
    bus.d_req = 0;
    tick();
    chk("w_no_dup", {bus.m_en, bus.d_ack}, 0);

    // Data write held through its ack: excluded that cycle, re-granted after.
    bus.d_req = 1; bus.d_addr = 32'h104; bus.d_wdata = 32'hCAFE_0001;
    tick();
    chk("wh_ack1", {bus.m_en, bus.d_ack}, 2'b11);
    tick();
    chk("wh_excl", {bus.m_en, bus.d_ack}, 0);
    chk("wh_stall", bus.cpu_stall, 1);
    tick();
    chk("wh_ack2", {bus.m_en, bus.d_ack}, 2'b11);
    chk("wh_addr2", bus.m_addr, 32'h104);
    bus.d_req = 0;
    tick();
    chk("wh_quiet", {bus.m_en, bus.d_ack}, 0);

    // Reset while a read is outstanding.
    bus.if_req = 1; bus.if_addr = 32'h50;
    tick();
    chk("r_m_en", bus.m_en, 1);
    reset = 1'b1;
    tick();
    chk("r_no_ack", bus.if_ack, 0);
    chk("r_m_en_off", bus.m_en, 0);
    chk("r_m_addr", bus.m_addr, 0);
    reset = 1'b0;
    bus.if_req = 0;
    tick();
    chk("r_still_no_ack", bus.if_ack, 0);
    chk("r_idle", bus.m_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
